// File: rtl/tx_protocol_pkg.sv
// Shared link-layer constants and framer state encoding.
package tx_protocol_pkg;

    localparam logic [7:0]  K28_5     = 8'hBC;
    localparam logic [7:0]  K23_7     = 8'hF7;
    localparam logic [7:0]  D16_2     = 8'h50;
    localparam logic [31:0] IDLE_WORD = {D16_2, D16_2, D16_2, K28_5};
    localparam logic [3:0]  K_BYTE0   = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_TRAILER
    } tx_state_e;

endpackage

// File: rtl/tx_checksum16.sv
// Modulo-2^16 running sum of data words; clear has priority over enable.
module tx_checksum16 (
    input  logic        clk240_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic [15:0] word_i,
    output logic [15:0] sum_o
);

    logic [15:0] sum_q;
    logic [15:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clear_i) begin
            sum_d = 16'h0000;
        end else if (en_i) begin
            sum_d = sum_q + word_i;
        end
    end

    always_ff @(posedge clk240_i or posedge rst_i) begin
        if (rst_i) begin
            sum_q <= 16'h0000;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/tx_protocol_framer.sv
// Link framer: IDLE comma stream, then HEADER / DATA x N / TRAILER frames on request.
//
// state      | meaning
// ST_IDLE    | comma idle word on the link, waiting for frame_start_i
// ST_HEADER  | header with bcid/bc0 on the link
// ST_DATA    | indexed payload words on the link
// ST_TRAILER | checksum/count trailer on the link; a start here chains the next frame
module tx_protocol_framer
    import tx_protocol_pkg::*;
#(
    parameter int USER_W          = 24,
    parameter int WORDS_PER_FRAME = 24,
    parameter int BCID_MAX        = 3563
) (
    input  logic              clk240_i,
    input  logic              rst_i,
    input  logic              frame_start_i,
    input  logic              bc0_i,
    input  logic [11:0]       bcid_i,
    input  logic [USER_W-1:0] tx_user_word_i,
    output logic              tx_user_ready_o,
    output logic              data_valid_o,
    output logic [31:0]       txdata_o,
    output logic [3:0]        txcharisk_o,
    output logic              err_overrun_o,
    output logic              err_bcid_o
);

    localparam logic [7:0]  WPF8       = 8'(WORDS_PER_FRAME);
    localparam logic [12:0] BCID_LIMIT = 13'(BCID_MAX);

    tx_state_e   state_q, state_d;
    logic [7:0]  remaining_q, remaining_d;
    logic [31:0] txdata_q, txdata_d;
    logic [3:0]  charisk_q, charisk_d;
    logic        valid_q, valid_d;
    logic        err_ovr_q, err_ovr_d;
    logic        err_bcid_q, err_bcid_d;
    logic        arm_q;
    logic        start_ok;
    logic        user_ready;
    logic [23:0] user_ext;
    logic [7:0]  idx;
    logic [15:0] chk_sum;

    // arm_q blocks a start sampled on the first edge after reset release.
    assign start_ok = frame_start_i & arm_q;
    assign user_ext = 24'(tx_user_word_i);
    assign idx      = WPF8 - remaining_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        txdata_d    = IDLE_WORD;
        charisk_d   = K_BYTE0;
        valid_d     = 1'b0;
        err_ovr_d   = err_ovr_q;
        err_bcid_d  = err_bcid_q;
        user_ready  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) state_d = ST_HEADER;
            end
            ST_HEADER: begin
                state_d    = ST_DATA;
                user_ready = 1'b1;
                if (start_ok) err_ovr_d = 1'b1;
            end
            ST_DATA: begin
                if (start_ok) err_ovr_d = 1'b1;
                if (remaining_q == 8'd0) begin
                    state_d = ST_TRAILER;
                end else begin
                    user_ready = 1'b1;
                end
            end
            ST_TRAILER: begin
                state_d = start_ok ? ST_HEADER : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Output word is registered, so it is chosen by the state being entered.
        case (state_d)
            ST_HEADER: begin
                txdata_d    = {4'h0, bcid_i, 7'h00, bc0_i, K28_5};
                valid_d     = 1'b1;
                remaining_d = WPF8;
                if ({1'b0, bcid_i} > BCID_LIMIT) err_bcid_d = 1'b1;
            end
            ST_DATA: begin
                txdata_d    = {idx, user_ext};
                charisk_d   = 4'b0000;
                valid_d     = 1'b1;
                remaining_d = remaining_q - 8'd1;
            end
            ST_TRAILER: begin
                txdata_d = {chk_sum, WPF8, K23_7};
                valid_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk240_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            remaining_q <= 8'd0;
            txdata_q    <= IDLE_WORD;
            charisk_q   <= K_BYTE0;
            valid_q     <= 1'b0;
            err_ovr_q   <= 1'b0;
            err_bcid_q  <= 1'b0;
            arm_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            txdata_q    <= txdata_d;
            charisk_q   <= charisk_d;
            valid_q     <= valid_d;
            err_ovr_q   <= err_ovr_d;
            err_bcid_q  <= err_bcid_d;
            arm_q       <= 1'b1;
        end
    end

    tx_checksum16 u_checksum (
        .clk240_i (clk240_i),
        .rst_i    (rst_i),
        .clear_i  (state_d == ST_HEADER),
        .en_i     (user_ready),
        .word_i   (user_ext[15:0]),
        .sum_o    (chk_sum)
    );

    assign tx_user_ready_o = user_ready;
    assign data_valid_o    = valid_q;
    assign txdata_o        = txdata_q;
    assign txcharisk_o     = charisk_q;
    assign err_overrun_o   = err_ovr_q;
    assign err_bcid_o      = err_bcid_q;

endmodule

// File: tb/tb_tx_protocol_framer.sv
// Directed bench for tx_protocol_framer: default instance plus a narrow 16-bit/4-word instance.
module tb_tx_protocol_framer;

    localparam logic [31:0] IDLE_W = 32'h505050BC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start_a = 1'b0, bc0_a = 1'b0;
    logic [11:0] bcid_a = 12'h000;
    logic [23:0] word_a = 24'h0;
    logic        rdy_a, val_a, eovr_a, ebcid_a;
    logic [31:0] data_a;
    logic [3:0]  k_a;

    logic        start_s = 1'b0, bc0_s = 1'b0;
    logic [11:0] bcid_s = 12'h000;
    logic [15:0] word_s = 16'h0;
    logic        rdy_s, val_s, eovr_s, ebcid_s;
    logic [31:0] data_s;
    logic [3:0]  k_s;

    int n_assert = 0;
    int n_fail   = 0;

    logic [35:0] q_a[$];
    logic [35:0] q_s[$];
    logic [35:0] exp_a, exp_s;

    always #2 clk = ~clk;

    tx_protocol_framer dut_a (
        .clk240_i        (clk),
        .rst_i           (rst),
        .frame_start_i   (start_a),
        .bc0_i           (bc0_a),
        .bcid_i          (bcid_a),
        .tx_user_word_i  (word_a),
        .tx_user_ready_o (rdy_a),
        .data_valid_o    (val_a),
        .txdata_o        (data_a),
        .txcharisk_o     (k_a),
        .err_overrun_o   (eovr_a),
        .err_bcid_o      (ebcid_a)
    );

    tx_protocol_framer #(.USER_W(16), .WORDS_PER_FRAME(4), .BCID_MAX(3563)) dut_s (
        .clk240_i        (clk),
        .rst_i           (rst),
        .frame_start_i   (start_s),
        .bc0_i           (bc0_s),
        .bcid_i          (bcid_s),
        .tx_user_word_i  (word_s),
        .tx_user_ready_o (rdy_s),
        .data_valid_o    (val_s),
        .txdata_o        (data_s),
        .txcharisk_o     (k_s),
        .err_overrun_o   (eovr_s),
        .err_bcid_o      (ebcid_s)
    );

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    // Scoreboards: every valid link word must match the next queued expectation.
    always @(negedge clk) begin
        if (val_a) begin
            n_assert++;
            assert (q_a.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_word_a: observed %h expected none", data_a);
            end
            if (q_a.size() > 0) begin
                exp_a = q_a.pop_front();
                chk("word_a", {k_a, data_a}, exp_a);
            end
        end
        if (val_s) begin
            n_assert++;
            assert (q_s.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_word_s: observed %h expected none", data_s);
            end
            if (q_s.size() > 0) begin
                exp_s = q_s.pop_front();
                chk("word_s", {k_s, data_s}, exp_s);
            end
        end
    end

    task automatic idle_chk(input string tag);
        chk({tag, "_data"}, {4'h0, data_a}, {4'h0, IDLE_W});
        chk({tag, "_k"}, {32'h0, k_a}, 36'h1);
        chk({tag, "_valid"}, {35'h0, val_a}, 36'h0);
    endtask

    // Called just after a negedge; returns at the negedge where the trailer is shown.
    task automatic run_frame(input bit sel, input bit bc0, input logic [11:0] bcid,
                             input int inject_at, input int abort_at);
        int          w;
        logic [15:0] sum;
        logic [23:0] u;
        logic [31:0] hdr;
        w   = sel ? 4 : 24;
        sum = 16'h0;
        hdr = {4'h0, bcid, 7'h00, bc0, 8'hBC};
        if (sel) begin
            start_s = 1'b1; bc0_s = bc0; bcid_s = bcid;
            q_s.push_back({4'b0001, hdr});
        end else begin
            start_a = 1'b1; bc0_a = bc0; bcid_a = bcid;
            q_a.push_back({4'b0001, hdr});
        end
        @(negedge clk);
        start_a = 1'b0;
        start_s = 1'b0;
        chk("hdr_latency", sel ? {k_s, data_s} : {k_a, data_a}, {4'b0001, hdr});
        for (int i = 0; i < w; i++) begin
            chk("ready_hi", {35'h0, (sel ? rdy_s : rdy_a)}, 36'h1);
            if (sel) begin
                u = {8'h00, 16'($urandom)};
                word_s = u[15:0];
                q_s.push_back({4'b0000, 8'(i), u});
            end else begin
                u = 24'hDE0000 | {16'h0, bcd(i + 1)};
                word_a = u;
                q_a.push_back({4'b0000, 8'(i), u});
            end
            sum = sum + u[15:0];
            if (i == inject_at) begin
                start_a = 1'b1; bc0_a = 1'b0; bcid_a = 12'h0AA;
            end
            @(negedge clk);
            start_a = 1'b0;
            if (i == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                idle_chk("in_reset");
                chk("rst_ready", {35'h0, rdy_a}, 36'h0);
                chk("rst_errs", {34'h0, eovr_a, ebcid_a}, 36'h0);
                rst = 1'b0;
                @(negedge clk);
                idle_chk("after_abort");
                return;
            end
        end
        chk("ready_lo", {35'h0, (sel ? rdy_s : rdy_a)}, 36'h0);
        if (sel) q_s.push_back({4'b0001, sum, 8'(w), 8'hF7});
        else     q_a.push_back({4'b0001, sum, 8'(w), 8'hF7});
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        idle_chk("reset");
        chk("reset_ready", {35'h0, rdy_a}, 36'h0);
        chk("reset_errs", {34'h0, eovr_a, ebcid_a}, 36'h0);
        chk("reset_s", {k_s, data_s}, {4'b0001, IDLE_W});

        // Start coincident with reset release is ignored.
        rst = 1'b0; start_a = 1'b1; bcid_a = 12'h005;
        @(negedge clk);
        start_a = 1'b0;
        idle_chk("rel_start");
        @(negedge clk);
        idle_chk("rel_start2");

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            idle_chk("idle");
        end

        run_frame(1'b0, 1'b1, 12'd0, -1, -1);
        @(negedge clk);
        idle_chk("post_frame");
        chk("errs_clean", {34'h0, eovr_a, ebcid_a}, 36'h0);

        run_frame(1'b0, 1'b0, 12'd0, -1, -1);
        run_frame(1'b0, 1'b0, 12'd4, -1, -1);
        @(negedge clk);
        idle_chk("post_b2b");
        chk("b2b_no_overrun", {35'h0, eovr_a}, 36'h0);

        run_frame(1'b0, 1'b0, 12'h123, 6, -1);
        @(negedge clk);
        idle_chk("post_overrun");
        chk("overrun_set", {35'h0, eovr_a}, 36'h1);
        repeat (3) @(negedge clk);
        idle_chk("no_extra_hdr");
        chk("overrun_sticky", {35'h0, eovr_a}, 36'h1);

        run_frame(1'b0, 1'b1, 12'd7, -1, 10);
        chk("abort_errs_clr", {35'h0, eovr_a}, 36'h0);
        run_frame(1'b0, 1'b0, 12'd9, -1, -1);
        @(negedge clk);
        idle_chk("post_abort_frame");

        run_frame(1'b0, 1'b0, 12'd3563, -1, -1);
        @(negedge clk);
        chk("bcid_max_ok", {35'h0, ebcid_a}, 36'h0);

        run_frame(1'b1, 1'b0, 12'd3564, -1, -1);
        @(negedge clk);
        chk("bcid_err_s", {35'h0, ebcid_s}, 36'h1);
        chk("valid_end_s", {35'h0, val_s}, 36'h0);
        chk("bcid_err_a_clear", {35'h0, ebcid_a}, 36'h0);

        repeat (2) @(negedge clk);
        chk("q_a_empty", 36'(q_a.size()), 36'h0);
        chk("q_s_empty", 36'(q_s.size()), 36'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_protocol_framer.md
TX_PROTOCOL_FRAMER -- requirements
Module: tx_protocol_framer

Interface
REQ-001 The block SHALL have parameter USER_W, default 24, meaning user payload width (1..24 bits, zero-extended to 24).
REQ-002 The block SHALL have parameter WORDS_PER_FRAME, default 24, meaning data words per frame (1..255).
REQ-003 The block SHALL have parameter BCID_MAX, default 3563, meaning the last valid bcid value.
REQ-004 The block SHALL have the port clk240_i, input, 1 bit, the single link clock; all logic is on its rising edge.
REQ-005 The block SHALL have the port rst_i, input, 1 bit, an asynchronous active-high reset.
REQ-006 The block SHALL have the port frame_start_i, input, 1 bit, a one-cycle strobe that requests a new frame.
REQ-007 The block SHALL have the port bc0_i, input, 1 bit, the BC0 flag, sampled with frame_start_i.
REQ-008 The block SHALL have the port bcid_i, input, 12 bits, the bunch-crossing id, sampled with frame_start_i.
REQ-009 The block SHALL have the port tx_user_word_i, input, USER_W bits, the payload, sampled every DATA cycle.
REQ-010 The block SHALL have the port tx_user_ready_o, output, 1 bit, high in each cycle in which tx_user_word_i is consumed.
REQ-011 The block SHALL have the port data_valid_o, output, 1 bit, high while a header, data or trailer word is on txdata_o.
REQ-012 The block SHALL have the port txdata_o, output, 32 bits, the registered link word.
REQ-013 The block SHALL have the port txcharisk_o, output, 4 bits, the per-byte K-character flags (bit0 = byte0).
REQ-014 The block SHALL have the port err_overrun_o, output, 1 bit, a sticky flag for a frame_start_i that was rejected.
REQ-015 The block SHALL have the port err_bcid_o, output, 1 bit, a sticky flag for a bcid_i value above BCID_MAX.

Function
REQ-016 The FSM SHALL have the states IDLE, HEADER, DATA and TRAILER.
REQ-017 In IDLE, txdata_o SHALL be 32'h505050BC, txcharisk_o SHALL be 4'b0001, and data_valid_o SHALL be 0.
REQ-018 A frame_start_i in IDLE SHALL latch bc0_i and bcid_i and cause the HEADER word to appear on txdata_o in the next cycle (1-cycle latency).
REQ-019 HEADER SHALL be {4'h0, bcid[11:0], 7'h0, bc0, 8'hBC}, with txcharisk_o = 4'b0001 and data_valid_o = 1; it lasts one cycle.
REQ-020 DATA SHALL last exactly WORDS_PER_FRAME cycles.
REQ-021 Each DATA word SHALL be {idx[7:0], zero-extended user word}, where idx runs from 0 to WORDS_PER_FRAME-1, with txcharisk_o = 4'b0000.
REQ-022 tx_user_ready_o SHALL be high in the cycle before each DATA word is output, i.e. combinationally aligned with the sampling edge.
REQ-023 TRAILER SHALL be {chk[15:0], WORDS_PER_FRAME[7:0], 8'hF7}, with txcharisk_o = 4'b0001; it lasts one cycle.
REQ-024 chk SHALL be the modulo-2^16 sum of bits [15:0] of all DATA words of the frame; the accumulator clears at HEADER.
REQ-025 A frame_start_i during TRAILER SHALL be accepted: the next HEADER follows the trailer with no idle word in between.
REQ-026 A frame_start_i during HEADER or DATA SHALL be ignored, the frame in progress SHALL complete unchanged, and err_overrun_o SHALL be set.
REQ-027 After TRAILER with no pending start, the FSM SHALL return to IDLE.
REQ-028 bcid_i > BCID_MAX at an accepted start SHALL set err_bcid_o, and the frame SHALL still be sent with bcid_i as given.
REQ-029 Error flags SHALL clear only on reset.

Reset
REQ-030 On rst_i, the FSM SHALL go to IDLE and the counters and checksum SHALL be cleared.
REQ-031 On rst_i, txdata_o SHALL be 32'h505050BC, txcharisk_o 4'b0001, and data_valid_o, tx_user_ready_o and both error flags 0.
REQ-032 Reset mid-frame SHALL abort the frame; no trailer is sent, and the first word after release SHALL be IDLE.
REQ-033 A frame_start_i coincident with the deassertion cycle of rst_i SHALL be ignored.

Structure
REQ-034 The shared package tx_protocol_pkg SHALL hold the K-character constants (K28_5 = 8'hBC, K23_7 = 8'hF7, D16_2 = 8'h50), the IDLE word, and the state enum.
REQ-035 The checksum accumulator SHALL be a sub-module, tx_checksum16 (clear, enable, 16-bit in, 16-bit sum).

Verification
REQ-036 Reset, then 10 idle cycles -> txdata_o = 32'h505050BC, txcharisk_o = 4'b0001 and data_valid_o = 0 throughout.
REQ-037 With default parameters, frame_start_i, bc0_i = 1, bcid_i = 0 and user words 24'hDE0001..24'hDE0024 -> header 32'h000001BC, data words 32'h00DE0001..32'h17DE0024, trailer {chk, 8'h18, 8'hF7} with chk matching the reference sum, then idle.
REQ-038 Back-to-back frames with the second start in TRAILER (bcid 0 then bcid 4) -> the second header, 32'h000400BC, immediately follows the first trailer.
REQ-039 A frame_start_i injected at DATA index 5 -> the frame is unaltered, err_overrun_o = 1, and no extra header appears.
REQ-040 rst_i pulsed at DATA index 10 -> the next word is IDLE, no trailer is sent, and a new start then yields a correct frame with a fresh checksum.
REQ-041 With USER_W = 16, WORDS_PER_FRAME = 4 and bcid_i = 3564 -> data words are zero-padded, the trailer count is 8'h04, and err_bcid_o = 1.
